// File: rtl/div16x8_seq.sv
// Sequential restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Define DIV_SEG_EN to add a registered seven-segment display of the state code.
`ifdef DIV_SEG_EN
module div16x8_seg7 (
  input  logic       clk,
  input  logic       reset_a,
  input  logic [2:0] code,
  output logic [6:0] seg
);
  // seg[6:0] = {a,b,c,d,e,f,g}
  always_ff @(posedge clk) begin
    if (reset_a) begin
      seg <= 7'b0000000;
    end else begin
      case (code)
        3'd0:    seg <= 7'b1111110;
        3'd1:    seg <= 7'b0110000;
        3'd2:    seg <= 7'b1101101;
        3'd3:    seg <= 7'b1001111;
        default: seg <= 7'b0000000;
      endcase
    end
  end
endmodule
`endif

// state | meaning
// IDLE  | waiting for start; last result held
// CALC  | shifting out one quotient bit per clock
// DONE  | result valid, waiting for start to drop
// ERR   | divide-by-zero or quotient overflow, waiting for start to drop
module div16x8_seq #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset_a,
  input  logic           start,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic [N-1:0]   quotient,
  output logic [N-1:0]   remainder,
  output logic           done_flag,
  output logic           err_flag,
  output logic           busy,
  output logic [2:0]     state_out
`ifdef DIV_SEG_EN
  ,
  output logic           seg_a,
  output logic           seg_b,
  output logic           seg_c,
  output logic           seg_d,
  output logic           seg_e,
  output logic           seg_f,
  output logic           seg_g
`endif
);
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t        state;
  logic [N:0]    r;
  logic [N-1:0]  q;
  logic [N-1:0]  dvs;
  logic [CW-1:0] count;

  logic [N:0]    t;
  logic          ge;
  logic [N:0]    r_next;
  logic [N-1:0]  q_next;

  assign t = {r[N-1:0], q[N-1]};

  // r[N] stays 0 while R < divisor holds; folding it in keeps the compare a true N+2-bit guard
  always_comb begin
    ge     = r[N] || (t >= {1'b0, dvs});
    r_next = ge ? (t - {1'b0, dvs}) : t;
    q_next = {q[N-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (reset_a) begin
      state     <= S_IDLE;
      r         <= '0;
      q         <= '0;
      dvs       <= '0;
      count     <= '0;
      quotient  <= '0;
      remainder <= '0;
      done_flag <= 1'b0;
      err_flag  <= 1'b0;
      busy      <= 1'b0;
      state_out <= 3'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            // divisor == 0 always satisfies the overflow test, so both errors share one path
            if ((divisor == '0) || (dividend[2*N-1:N] >= divisor)) begin
              state     <= S_ERR;
              state_out <= {1'b0, S_ERR};
              err_flag  <= 1'b1;
              quotient  <= '0;
              remainder <= '0;
            end else begin
              state     <= S_CALC;
              state_out <= {1'b0, S_CALC};
              busy      <= 1'b1;
              r         <= {1'b0, dividend[2*N-1:N]};
              q         <= dividend[N-1:0];
              dvs       <= divisor;
              count     <= '0;
            end
          end
        end
        S_CALC: begin
          r     <= r_next;
          q     <= q_next;
          count <= count + CW'(1);
          if (count == LAST) begin
            state     <= S_DONE;
            state_out <= {1'b0, S_DONE};
            busy      <= 1'b0;
            done_flag <= 1'b1;
            quotient  <= q_next;
            remainder <= r_next[N-1:0];
          end
        end
        S_DONE, S_ERR: begin
          if (!start) begin
            state     <= S_IDLE;
            state_out <= {1'b0, S_IDLE};
            done_flag <= 1'b0;
            err_flag  <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          state_out <= 3'd0;
          busy      <= 1'b0;
          done_flag <= 1'b0;
          err_flag  <= 1'b0;
        end
      endcase
    end
  end

`ifdef DIV_SEG_EN
  logic [6:0] seg;

  div16x8_seg7 u_seg7 (
    .clk     (clk),
    .reset_a (reset_a),
    .code    (state_out),
    .seg     (seg)
  );

  assign {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = seg;
`endif

endmodule

// File: tb/tb_div16x8_seq.sv
// Directed bench for div16x8_seq: hand-computed quotient/remainder vectors, error paths,
// mid-operation reset and start-handshake behaviour.
module tb_div16x8_seq;
  logic        clk = 1'b0;
  logic        reset_a = 1'b1;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic [7:0]  quotient;
  logic [7:0]  remainder;
  logic        done_flag;
  logic        err_flag;
  logic        busy;
  logic [2:0]  state_out;
`ifdef DIV_SEG_EN
  logic seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q = '0;
  logic [7:0] exp_r = '0;

  always #5 clk = ~clk;

  div16x8_seq #(.N(8)) dut (
    .clk       (clk),
    .reset_a   (reset_a),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .done_flag (done_flag),
    .err_flag  (err_flag),
    .busy      (busy),
    .state_out (state_out)
`ifdef DIV_SEG_EN
    ,
    .seg_a     (seg_a),
    .seg_b     (seg_b),
    .seg_c     (seg_c),
    .seg_d     (seg_d),
    .seg_e     (seg_e),
    .seg_f     (seg_f),
    .seg_g     (seg_g)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launch edge, eight CALC edges, then check DONE. With meddle set, start toggles and the
  // operands are scrambled during CALC, and start is left high at completion.
  task automatic run_div(input string tag, input logic [15:0] dvd, input logic [7:0] dvs,
                         input logic [7:0] eq, input logic [7:0] er, input bit meddle);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    tick();
    check({tag, "_launch_busy"}, busy, 1'b1);
    check({tag, "_launch_state"}, state_out, 3'd1);
    for (int i = 1; i <= 8; i++) begin
      if (meddle) begin
        start    = (i % 2 == 0) ? 1'b1 : 1'b0;
        dividend = 16'hFFFF - 16'(i);
        divisor  = 8'(i);
      end else begin
        start = 1'b0;
      end
      tick();
      if (i < 8) begin
        check({tag, "_calc_busy"}, busy, 1'b1);
        check({tag, "_calc_done"}, done_flag, 1'b0);
        check({tag, "_calc_q_held"}, quotient, exp_q);
        check({tag, "_calc_r_held"}, remainder, exp_r);
      end
    end
    check({tag, "_done"}, done_flag, 1'b1);
    check({tag, "_done_busy"}, busy, 1'b0);
    check({tag, "_done_err"}, err_flag, 1'b0);
    check({tag, "_done_state"}, state_out, 3'd2);
    check({tag, "_quotient"}, quotient, eq);
    check({tag, "_remainder"}, remainder, er);
    exp_q = eq;
    exp_r = er;
  endtask

  task automatic release_start(input string tag);
    start = 1'b0;
    tick();
    check({tag, "_idle_state"}, state_out, 3'd0);
    check({tag, "_idle_done"}, done_flag, 1'b0);
    check({tag, "_idle_err"}, err_flag, 1'b0);
    check({tag, "_keep_q"}, quotient, exp_q);
    check({tag, "_keep_r"}, remainder, exp_r);
  endtask

  task automatic err_case(input string tag, input logic [15:0] dvd, input logic [7:0] dvs);
    dividend = dvd;
    divisor  = dvs;
    start    = 1'b1;
    tick();
    check({tag, "_err"}, err_flag, 1'b1);
    check({tag, "_done"}, done_flag, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_state"}, state_out, 3'd3);
    check({tag, "_q_zero"}, quotient, 8'h00);
    check({tag, "_r_zero"}, remainder, 8'h00);
    tick();
    check({tag, "_err_hold"}, err_flag, 1'b1);
    check({tag, "_busy_hold"}, busy, 1'b0);
`ifdef DIV_SEG_EN
    check({tag, "_seg_E"}, {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g}, 7'b1001111);
`endif
    exp_q = '0;
    exp_r = '0;
    release_start(tag);
  endtask

  initial begin
    tick();
    tick();
    check("rst_state", state_out, 3'd0);
    check("rst_q", quotient, 8'h00);
    check("rst_r", remainder, 8'h00);
    check("rst_done", done_flag, 1'b0);
    check("rst_err", err_flag, 1'b0);
    check("rst_busy", busy, 1'b0);
`ifdef DIV_SEG_EN
    check("rst_seg", {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g}, 7'b0000000);
`endif
    reset_a = 1'b0;
    tick();
`ifdef DIV_SEG_EN
    check("idle_seg_0", {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g}, 7'b1111110);
`endif

    run_div("d12345", 16'h3039, 8'h64, 8'h7B, 8'h2D, 1'b0);
    release_start("d12345");

    run_div("dfeff", 16'hFEFF, 8'hFF, 8'hFF, 8'hFE, 1'b0);
    release_start("dfeff");

    run_div("d00ff", 16'h00FF, 8'h01, 8'hFF, 8'h00, 1'b0);
    release_start("d00ff");

    // Reset asserted for the 4th CALC edge: must abort with everything cleared
    dividend = 16'h3039;
    divisor  = 8'h64;
    start    = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("midrst_busy_before", busy, 1'b1);
    reset_a = 1'b1;
    tick();
    check("midrst_state", state_out, 3'd0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done_flag, 1'b0);
    check("midrst_err", err_flag, 1'b0);
    check("midrst_q", quotient, 8'h00);
    check("midrst_r", remainder, 8'h00);
    reset_a = 1'b0;
    exp_q = '0;
    exp_r = '0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("midrst_no_done", done_flag, 1'b0);
      check("midrst_stay_idle", state_out, 3'd0);
    end
    run_div("after_rst", 16'h3039, 8'h64, 8'h7B, 8'h2D, 1'b0);
    release_start("after_rst");

    err_case("div0", 16'h1234, 8'h00);
    err_case("ovf", 16'h6400, 8'h64);

    // Held start plus operand/start noise during CALC
    run_div("hold", 16'hFEFF, 8'hFF, 8'hFF, 8'hFE, 1'b1);
    dividend = 16'h3039;
    divisor  = 8'h64;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_state", state_out, 3'd2);
      check("hold_done", done_flag, 1'b1);
      check("hold_busy", busy, 1'b0);
      check("hold_q", quotient, 8'hFF);
    end
    release_start("hold");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
